// File: rtl/game_scan_gen_if.sv
// Scan outputs from game_scan_gen: sync, blanking, and the game-window coordinates and strobes.
interface game_scan_gen_if #(
    parameter int unsigned GAME_W = 224,
    parameter int unsigned GAME_H = 288
);
    localparam int unsigned SXW = $clog2(GAME_W);
    localparam int unsigned SYW = $clog2(GAME_H);

    logic           hsync;
    logic           vsync;
    logic           display_enabled;
    logic           game_active;
    logic           game_pix_stb;
    logic           frame_stb;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic           border;

    modport master (
        output hsync, vsync, display_enabled, game_active, game_pix_stb,
               frame_stb, sx, sy, border
    );
    modport slave (
        input  hsync, vsync, display_enabled, game_active, game_pix_stb,
               frame_stb, sx, sy, border
    );
endinterface

// File: rtl/game_scan_gen.sv
// VGA raster counters plus a centred, integer-scaled game window; all outputs registered one cycle after hc/vc.
// Optional GAME_BORDER_EN adds a one-pixel frame around the window on the border output.
module game_scan_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned GAME_W    = 224,
    parameter int unsigned GAME_H    = 288,
    parameter int unsigned SCALE     = 1
) (
    input  logic              vga_pix_clk,
    input  logic              rst,
    game_scan_gen_if.master   scan
);
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HCW      = $clog2(H_TOTAL);
    localparam int unsigned VCW      = $clog2(V_TOTAL);
    localparam int unsigned SXW      = $clog2(GAME_W);
    localparam int unsigned SYW      = $clog2(GAME_H);
    localparam int unsigned SHIFT    = $clog2(SCALE);
    localparam int unsigned WIN_W    = GAME_W * SCALE;
    localparam int unsigned WIN_H    = GAME_H * SCALE;
    localparam int unsigned H_OFF    = (H_VISIBLE - WIN_W) / 2;
    localparam int unsigned V_OFF    = (V_VISIBLE - WIN_H) / 2;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HCW-1:0] hc;
    logic [VCW-1:0] vc;

    // Raster counters: vc advances on the hc wrap, both wrap together at frame end
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HCW'(H_TOTAL - 1)) begin
            hc <= '0;
            vc <= (vc == VCW'(V_TOTAL - 1)) ? '0 : vc + VCW'(1);
        end else begin
            hc <= hc + HCW'(1);
        end
    end

    logic           hsync_nxt, vsync_nxt, de_nxt, active_nxt, pix_stb_nxt, frame_nxt, border_nxt;
    logic [SXW-1:0] sx_nxt;
    logic [SYW-1:0] sy_nxt;
    logic           h_win, v_win;
    logic [HCW-1:0] hrel;
    logic [VCW-1:0] vrel;

    always_comb begin
        hsync_nxt   = 1'b1;
        vsync_nxt   = 1'b1;
        de_nxt      = 1'b0;
        active_nxt  = 1'b0;
        pix_stb_nxt = 1'b0;
        frame_nxt   = 1'b0;
        border_nxt  = 1'b0;
        sx_nxt      = '0;
        sy_nxt      = '0;

        hrel  = hc - HCW'(H_OFF);
        vrel  = vc - VCW'(V_OFF);
        h_win = (hc >= HCW'(H_OFF)) && (hc < HCW'(H_OFF + WIN_W));
        v_win = (vc >= VCW'(V_OFF)) && (vc < VCW'(V_OFF + WIN_H));

        hsync_nxt  = !((hc >= HCW'(HS_START)) && (hc < HCW'(HS_END)));
        vsync_nxt  = !((vc >= VCW'(VS_START)) && (vc < VCW'(VS_END)));
        de_nxt     = (hc < HCW'(H_VISIBLE)) && (vc < VCW'(V_VISIBLE));
        frame_nxt  = (hc == '0) && (vc == '0);
        active_nxt = h_win && v_win;

        // Coordinates stay zero outside the window so they never exceed the game range
        if (active_nxt) begin
            sx_nxt      = SXW'(hrel >> SHIFT);
            sy_nxt      = SYW'(vrel >> SHIFT);
            pix_stb_nxt = ((hrel & HCW'(SCALE - 1)) == '0) && ((vrel & VCW'(SCALE - 1)) == '0);
        end

`ifdef GAME_BORDER_EN
        border_nxt =
            (((hc == HCW'(H_OFF - 1)) || (hc == HCW'(H_OFF + WIN_W))) &&
             (vc >= VCW'(V_OFF - 1)) && (vc <= VCW'(V_OFF + WIN_H))) ||
            (((vc == VCW'(V_OFF - 1)) || (vc == VCW'(V_OFF + WIN_H))) &&
             (hc >= HCW'(H_OFF - 1)) && (hc <= HCW'(H_OFF + WIN_W)));
`else
        border_nxt = 1'b0;
`endif
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            scan.hsync           <= 1'b1;
            scan.vsync           <= 1'b1;
            scan.display_enabled <= 1'b0;
            scan.game_active     <= 1'b0;
            scan.game_pix_stb    <= 1'b0;
            scan.frame_stb       <= 1'b0;
            scan.sx              <= '0;
            scan.sy              <= '0;
            scan.border          <= 1'b0;
        end else begin
            scan.hsync           <= hsync_nxt;
            scan.vsync           <= vsync_nxt;
            scan.display_enabled <= de_nxt;
            scan.game_active     <= active_nxt;
            scan.game_pix_stb    <= pix_stb_nxt;
            scan.frame_stb       <= frame_nxt;
            scan.sx              <= sx_nxt;
            scan.sy              <= sy_nxt;
            scan.border          <= border_nxt;
        end
    end
endmodule
